// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction assembler with range checks.
// Two-stage valid/ready pipeline (S1 check/pack, S2 output) with status counters.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_opcode..in_imm     opcode, register fields, funct fields, signed imm
//   out_valid/out_ready   result handshake
//   out_instr, out_err    packed word (0 when illegal) and error flag
//   enc_count, err_count  saturating counts of words handed off
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    fmt_e               fmt;
    logic signed [31:0] simm;
    logic               i_ok;
    logic               b_ok;
    logic               j_ok;
    logic               u_ok;
    logic [31:0]        pack_word;
    logic               pack_err;

    logic               s1_valid;
    logic [31:0]        s1_instr;
    logic               s1_err;
    logic               s2_open;
    logic               out_fire;

    // Format select from opcode
    always_comb begin
        fmt = FMT_X;
        unique case (in_opcode)
            OP_R:                     fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BR:                    fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  fmt = FMT_X;
        endcase
    end

    // Immediate range checks; I and S share the 12-bit signed range
    assign simm = $signed(in_imm);
    assign i_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign b_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094)
                  && !in_imm[0];
    assign j_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574)
                  && !in_imm[0];
    assign u_ok = (in_imm[11:0] == 12'd0);

    // Field packing; an illegal request always yields an all-zero word
    always_comb begin
        pack_word = '0;
        pack_err  = 1'b0;
        unique case (fmt)
            FMT_R: begin
                pack_word = {in_funct7, in_rs2, in_rs1, in_funct3,
                             in_rd, in_opcode};
            end
            FMT_I: begin
                pack_err  = !i_ok;
                pack_word = {in_imm[11:0], in_rs1, in_funct3,
                             in_rd, in_opcode};
            end
            FMT_S: begin
                pack_err  = !i_ok;
                pack_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:0], in_opcode};
            end
            FMT_B: begin
                pack_err  = !b_ok;
                pack_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                             in_funct3, in_imm[4:1], in_imm[11],
                             in_opcode};
            end
            FMT_U: begin
                pack_err  = !u_ok;
                pack_word = {in_imm[31:12], in_rd, in_opcode};
            end
            FMT_J: begin
                pack_err  = !j_ok;
                pack_word = {in_imm[20], in_imm[10:1], in_imm[11],
                             in_imm[19:12], in_rd, in_opcode};
            end
            default: begin
                pack_err = 1'b1;
            end
        endcase
        if (pack_err) begin
            pack_word = '0;
        end
    end

    // S2 can take a word when empty or draining this cycle; S1 can take
    // one when empty or when its word moves into S2.
    assign s2_open  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_open;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_instr  <= '0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_instr <= pack_word;
                    s1_err   <= pack_err;
                end
            end
            if (s2_open) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= s1_instr;
                    out_err   <= s1_err;
                end
            end
            if (out_fire) begin
                if (!out_err) begin
                    if (enc_count != CNT_MAX) begin
                        enc_count <= enc_count + 1'b1;
                    end
                end else begin
                    if (err_count != CNT_MAX) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule
